iu: RTL and testbench



---
 rtl/iu_pkg.sv | 25 ++
 rtl/iu_rom.sv | 12 +
 rtl/iu.sv | 35 +++
 tb/tb_iu.sv | 134 +++++++++++++
 4 files changed

// File: rtl/iu_pkg.sv
// Shared widths, types and program image for the instruction unit (fetch stage).
// The ROM image is a fixed 32-word program; addresses 6..31 are NOPs.
package iu_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 13;
    localparam int ROM_DEPTH = 2 ** PC_W;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP = 13'h0000;

    localparam instr_t ROM_IMAGE [ROM_DEPTH] = '{
        13'h0A01, 13'h1203, 13'h0405, 13'h1C07,
        13'h1FFF, 13'h0000, NOP,      NOP,
        NOP,      NOP,      NOP,      NOP,
        NOP,      NOP,      NOP,      NOP,
        NOP,      NOP,      NOP,      NOP,
        NOP,      NOP,      NOP,      NOP,
        NOP,      NOP,      NOP,      NOP,
        NOP,      NOP,      NOP,      NOP
    };

endpackage

// File: rtl/iu_rom.sv
// Program ROM: purely combinational lookup of the fixed image.
// Every pc value maps to a real entry, so there is no out-of-range path.
module iu_rom
    import iu_pkg::*;
(
    input  pc_t    addr,
    output instr_t data
);

    assign data = ROM_IMAGE[addr];

endmodule

// File: rtl/iu.sv
// Instruction unit fetch stage: free-running PC and the instruction register.
// The IR captures the word at the current PC on the same edge the PC advances.
module iu
    import iu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    output pc_t    pcOut,
    output instr_t ir_out
);

    pc_t    pc;
    instr_t ir;
    instr_t rom_data;

    iu_rom u_rom (
        .addr (pc),
        .data (rom_data)
    );

    // Release from reset is not synchronised here; that is handled upstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            ir <= '0;
        end else begin
            ir <= rom_data;
            pc <= pc + pc_t'(1);
        end
    end

    assign pcOut  = pc;
    assign ir_out = ir;

endmodule

// File: tb/tb_iu.sv
// Directed self-checking bench for the iu fetch stage.
// Expected values come from a hand-written copy of the program and a local PC model.
module tb_iu;

    logic        clk;
    logic        reset;
    logic [4:0]  pcOut;
    logic [12:0] ir_out;

    int total = 0;
    int bad   = 0;

    logic [12:0] tbrom [32];
    logic [4:0]  mpc;
    logic [12:0] mir;

    iu dut (
        .clk    (clk),
        .reset  (reset),
        .pcOut  (pcOut),
        .ir_out (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before sampling.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] epc, input logic [12:0] eir);
        total++;
        assert (pcOut === epc) else begin
            bad++;
            $error("FAIL %s pc: got %h want %h", tag, pcOut, epc);
        end
        total++;
        assert (ir_out === eir) else begin
            bad++;
            $error("FAIL %s ir: got %h want %h", tag, ir_out, eir);
        end
    endtask

    task automatic modelEdge();
        mir = tbrom[mpc];
        mpc = mpc + 5'd1;
    endtask

    task automatic startFetch();
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        mpc = 5'd0;
        mir = 13'h0000;
    endtask

    initial begin
        logic [4:0] prev;

        for (int i = 0; i < 32; i++) tbrom[i] = 13'h0000;
        tbrom[0] = 13'h0A01;
        tbrom[1] = 13'h1203;
        tbrom[2] = 13'h0405;
        tbrom[3] = 13'h1C07;
        tbrom[4] = 13'h1FFF;
        tbrom[5] = 13'h0000;

        reset = 1'b0;
        #2;
        checkOutput("reset_t0", 5'd0, 13'h0000);
        applyStimulus();
        applyStimulus();
        checkOutput("reset_2cyc", 5'd0, 13'h0000);

        // Held in reset across three more edges: no fetch may happen.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("reset_hold%0d", i), 5'd0, 13'h0000);
        end

        // Sequential fetch right after release.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        checkOutput("seq1", 5'd1, 13'h0A01);
        applyStimulus();
        checkOutput("seq2", 5'd2, 13'h1203);
        applyStimulus();
        checkOutput("seq3", 5'd3, 13'h0405);
        applyStimulus();
        checkOutput("seq4", 5'd4, 13'h1C07);
        applyStimulus();
        checkOutput("seq5", 5'd5, 13'h1FFF);
        applyStimulus();
        checkOutput("seq6", 5'd6, 13'h0000);

        // Asynchronous reset in mid-run, asserted between edges at pc=4.
        startFetch();
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("mid_pre", 5'd4, 13'h1C07);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_async", 5'd0, 13'h0000);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        checkOutput("mid_restart", 5'd1, 13'h0A01);

        // Wrap and invariant over 40 edges against the local model.
        startFetch();
        for (int i = 1; i <= 40; i++) begin
            applyStimulus();
            modelEdge();
            checkOutput($sformatf("run%0d", i), mpc, mir);
            prev = pcOut - 5'd1;
            total++;
            assert (ir_out === tbrom[prev]) else begin
                bad++;
                $error("FAIL inv%0d ir: got %h want %h", i, ir_out, tbrom[prev]);
            end
            if (i == 32) checkOutput("wrap32", 5'd0, 13'h0000);
            if (i == 33) checkOutput("wrap33", 5'd1, 13'h0A01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
